// File: rtl/se_squeeze_reader.sv
// SE squeeze read sequencer: walks each channel of the pooling BRAM through the 4-wide read port,
// accumulates a signed per-channel sum and hands sum/average to the FC stage over valid/ready.
module se_squeeze_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned ACC_WIDTH  = 48,
    parameter int unsigned CH_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] hw_size,
    input  logic [CH_WIDTH-1:0]   num_ch,
    input  logic [4:0]            avg_shift,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [DATA_WIDTH-1:0] rd_data1,
    input  logic [DATA_WIDTH-1:0] rd_data2,
    input  logic [DATA_WIDTH-1:0] rd_data3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic [DATA_WIDTH-1:0] out_avg,
    output logic [CH_WIDTH-1:0]   out_ch,
    output logic                  busy,
    output logic                  done
);

    // One extra bit so offset+4 never wraps when compared against hw_size.
    localparam int unsigned OffWidth = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StOut, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ch_base_q, ch_base_d;
    logic [OffWidth-1:0]   offset_q, offset_d;
    logic                  dly_valid_q;
    logic [OffWidth-1:0]   dly_off_q;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] hw_q, hw_d;
    logic [CH_WIDTH-1:0]   num_ch_q, num_ch_d;
    logic [4:0]            shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ACC_WIDTH-1:0]  out_sum_q, out_sum_d;
    logic [DATA_WIDTH-1:0] out_avg_q, out_avg_d;

    logic [DATA_WIDTH-1:0] lane [4];
    logic [ACC_WIDTH-1:0]  lane_sum;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [OffWidth-1:0]   off_next;

    assign lane[0] = rd_data0;
    assign lane[1] = rd_data1;
    assign lane[2] = rd_data2;
    assign lane[3] = rd_data3;

    // Lanes past the channel extent may hold the next channel's words; drop them.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 4; i++) begin
            if (dly_off_q + OffWidth'(i) < {1'b0, hw_q}) begin
                lane_sum = lane_sum +
                    {{(ACC_WIDTH - DATA_WIDTH){lane[i][DATA_WIDTH-1]}}, lane[i]};
            end
        end
        acc_next = dly_valid_q ? acc_q + lane_sum : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        ch_base_d = ch_base_q;
        offset_d  = offset_q;
        acc_d     = acc_next;
        ch_d      = ch_q;
        hw_d      = hw_q;
        num_ch_d  = num_ch_q;
        shift_d   = shift_q;
        rd_addr_d = rd_addr_q;
        out_sum_d = out_sum_q;
        out_avg_d = out_avg_q;
        off_next  = offset_q + OffWidth'(4);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hw_d     = hw_size;
                    num_ch_d = num_ch;
                    shift_d  = avg_shift;
                    if (hw_size == '0 || num_ch == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StRead;
                        ch_base_d = base_addr;
                        rd_addr_d = base_addr;
                        offset_d  = '0;
                        ch_d      = '0;
                        acc_d     = '0;
                    end
                end
            end
            StRead: begin
                if (off_next >= {1'b0, hw_q}) begin
                    state_d = StDrain;
                end else begin
                    offset_d  = off_next;
                    rd_addr_d = ch_base_q + off_next[ADDR_WIDTH-1:0];
                end
            end
            StDrain: begin
                state_d   = StOut;
                out_sum_d = acc_next;
                out_avg_d = DATA_WIDTH'($signed(acc_next) >>> shift_q);
            end
            StOut: begin
                if (out_ready) begin
                    if (ch_q == num_ch_q - CH_WIDTH'(1)) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StRead;
                        ch_d      = ch_q + CH_WIDTH'(1);
                        ch_base_d = ch_base_q + hw_q;
                        rd_addr_d = ch_base_q + hw_q;
                        offset_d  = '0;
                        acc_d     = '0;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ch_base_q   <= '0;
            offset_q    <= '0;
            dly_valid_q <= 1'b0;
            dly_off_q   <= '0;
            acc_q       <= '0;
            ch_q        <= '0;
            hw_q        <= '0;
            num_ch_q    <= '0;
            shift_q     <= '0;
            rd_addr_q   <= '0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_base_q   <= ch_base_d;
            offset_q    <= offset_d;
            dly_valid_q <= (state_q == StRead);
            dly_off_q   <= offset_q;
            acc_q       <= acc_d;
            ch_q        <= ch_d;
            hw_q        <= hw_d;
            num_ch_q    <= num_ch_d;
            shift_q     <= shift_d;
            rd_addr_q   <= rd_addr_d;
            out_sum_q   <= out_sum_d;
            out_avg_q   <= out_avg_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_valid = (state_q == StOut);
    assign out_sum   = out_sum_q;
    assign out_avg   = out_avg_q;
    assign out_ch    = ch_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_se_squeeze_reader.sv
// Bench for se_squeeze_reader: table of jobs against a synchronous-read BRAM model, plus
// hand-written reset and abort sequences.
module tb_se_squeeze_reader;

    localparam int DW = 32;
    localparam int AW = 20;
    localparam int AccW = 48;
    localparam int CW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW-1:0]   hw_size;
    logic [CW-1:0]   num_ch;
    logic [4:0]      avg_shift;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data0 = '0;
    logic [DW-1:0]   rd_data1 = '0;
    logic [DW-1:0]   rd_data2 = '0;
    logic [DW-1:0]   rd_data3 = '0;
    logic            out_valid;
    logic            out_ready;
    logic [AccW-1:0] out_sum;
    logic [DW-1:0]   out_avg;
    logic [CW-1:0]   out_ch;
    logic            busy;
    logic            done;

    se_squeeze_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .hw_size   (hw_size),
        .num_ch    (num_ch),
        .avg_shift (avg_shift),
        .rd_addr   (rd_addr),
        .rd_data0  (rd_data0),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_data3  (rd_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .out_ch    (out_ch),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];

    always @(posedge clk) begin
        rd_data0 <= mem[rd_addr[7:0]];
        rd_data1 <= mem[rd_addr[7:0] + 8'd1];
        rd_data2 <= mem[rd_addr[7:0] + 8'd2];
        rd_data3 <= mem[rd_addr[7:0] + 8'd3];
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int     base;
        int     hw;
        int     nch;
        int     shift;
        int     fill;
        int     stall;
        int     nres;
        longint sum0;
        longint avg0;
        longint sum1;
        longint avg1;
        int     first;
        int     done_at;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill_mem(input int kind);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                0: mem[i] = DW'(i);
                1: mem[i] = (i >= 100 && i <= 148) ? 32'd1 :
                            (i >= 149 && i <= 151) ? 32'd1000 : 32'd0;
                default: mem[i] = (i < 4) ? 32'hFFFF_FFFD : 32'd77;
            endcase
        end
    endtask

    task automatic run_job(input int idx);
        vec_t   v;
        longint got_sum [2];
        longint got_avg [2];
        longint got_ch [2];
        int     nres;
        int     first;
        int     done_at;
        int     stalls;
        int     g;
        bit     busy_ok;
        bit     addr_ok;
        bit     hold_ok;
        v = vecs[idx];
        nres = 0; first = -1; done_at = -1; stalls = 0;
        busy_ok = 1'b1; addr_ok = 1'b1; hold_ok = 1'b1;
        got_sum = '{0, 0}; got_avg = '{0, 0}; got_ch = '{0, 0};
        g = (v.hw + 3) / 4;
        fill_mem(v.fill);
        base_addr = AW'(v.base);
        hw_size   = AW'(v.hw);
        num_ch    = CW'(v.nch);
        avg_shift = 5'(v.shift);
        out_ready = 1'b1;
        start     = 1'b1;
        cyc = 0;
        tick();
        for (int k = 0; k < 300 && done_at < 0; k++) begin
            // A second start with different config mid-job must change nothing.
            if (v.nres > 0 && cyc == 2) begin
                start = 1'b1; base_addr = 7; hw_size = 3; num_ch = 5; avg_shift = 1;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (v.nres > 0 && cyc <= g && rd_addr !== AW'(v.base + 4 * (cyc - 1))) addr_ok = 1'b0;
            if (out_valid && first < 0) first = cyc;
            if (done) done_at = cyc;
            out_ready = !(v.stall != 0 && out_valid && nres == 0 && stalls < 5);
            if (out_valid && !out_ready) begin
                stalls++;
                if (!($signed(out_sum) == v.sum0 && out_ch == '0 &&
                      rd_addr == AW'(v.base + 4 * (g - 1)))) hold_ok = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (nres < 2) begin
                    got_sum[nres] = $signed(out_sum);
                    got_avg[nres] = $signed(out_avg);
                    got_ch[nres]  = longint'(out_ch);
                end
                nres++;
            end
            if (done_at < 0) tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        check($sformatf("v%0d first_valid_cycle", idx), first, v.first);
        check($sformatf("v%0d done_cycle", idx), done_at, v.done_at);
        check($sformatf("v%0d result_count", idx), nres, v.nres);
        check($sformatf("v%0d busy_during_job", idx), busy_ok, 1);
        if (v.nres >= 1) begin
            check($sformatf("v%0d ch0_sum", idx), got_sum[0], v.sum0);
            check($sformatf("v%0d ch0_avg", idx), got_avg[0], v.avg0);
            check($sformatf("v%0d ch0_index", idx), got_ch[0], 0);
            check($sformatf("v%0d rd_addr_seq", idx), addr_ok, 1);
        end
        if (v.nres >= 2) begin
            check($sformatf("v%0d ch1_sum", idx), got_sum[1], v.sum1);
            check($sformatf("v%0d ch1_avg", idx), got_avg[1], v.avg1);
            check($sformatf("v%0d ch1_index", idx), got_ch[1], 1);
        end
        if (v.stall != 0) begin
            check($sformatf("v%0d stall_cycles", idx), stalls, 5);
            check($sformatf("v%0d held_during_stall", idx), hold_ok, 1);
        end
        tick();
        check($sformatf("v%0d busy_after_done", idx), busy, 0);
        check($sformatf("v%0d done_single_cycle", idx), done, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " rd_addr"}, rd_addr, 0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_sum"}, out_sum, 0);
        check({tag, " out_avg"}, out_avg, 0);
        check({tag, " out_ch"}, out_ch, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
    endtask

    initial begin
        bit quiet;
        //          base  hw nch sh fill stall nres sum0 avg0 sum1 avg1 first done
        vecs[0] = '{0,   16, 2, 4, 0, 0, 2, 120, 7, 376, 23, 6, 13};
        vecs[1] = '{100, 49, 1, 0, 1, 0, 1, 49, 49, 0, 0, 15, 16};
        vecs[2] = '{0,   4,  1, 2, 2, 0, 1, -12, -3, 0, 0, 3, 4};
        vecs[3] = '{0,   16, 2, 4, 0, 1, 2, 120, 7, 376, 23, 6, 18};
        vecs[4] = '{0,   6,  2, 1, 0, 0, 2, 15, 7, 51, 25, 4, 9};
        vecs[5] = '{0,   16, 0, 4, 0, 0, 0, 0, 0, 0, 0, -1, 1};
        vecs[6] = '{0,   0,  2, 4, 0, 0, 0, 0, 0, 0, 0, -1, 1};

        fill_mem(0);
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        base_addr = '0; hw_size = '0; num_ch = '0; avg_shift = '0;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_job(i);

        // Abort in READ, then confirm the block is silent and a fresh job matches.
        fill_mem(0);
        base_addr = 0; hw_size = 16; num_ch = 2; avg_shift = 4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_zero_outputs("abort");
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid || done || busy) quiet = 1'b0;
        end
        check("abort quiet_after_reset", quiet, 1);
        run_job(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
